// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph codes, slot indices,
// FSM state encoding and the shift-add decimal accumulate helper.
package seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b1111110;

    localparam logic [1:0] SLOT_UNITS    = 2'd0;
    localparam logic [1:0] SLOT_TENS     = 2'd1;
    localparam logic [1:0] SLOT_HUNDREDS = 2'd2;
    localparam logic [1:0] SLOT_SIGN     = 2'd3;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_CONV_H  = 3'd1,
        ST_CONV_T  = 3'd2,
        ST_CONV_U  = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

    // acc*10 + d without a multiplier: (acc<<3) + (acc<<1)
    function automatic logic [9:0] mul10_add(input logic [9:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {6'd0, d};
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed 7-segment driver (master) and the scan decoder (slave).
interface seg_scan_decoder_if;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic [8:0]  VALUE;
    logic [11:0] DIGITS;
    logic        SIGN;
    logic        VALID;
    logic        ERR;
    logic        TMO;

    modport master (
        output SEG, AN,
        input  VALUE, DIGITS, SIGN, VALID, ERR, TMO
    );

    modport slave (
        input  SEG, AN,
        output VALUE, DIGITS, SIGN, VALID, ERR, TMO
    );
endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational active-low 7-segment glyph to BCD digit decoder; flags any
// pattern that is not one of the ten digit glyphs.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       bad,
    output logic [3:0] digit
);

    always_comb begin
        bad   = 1'b0;
        digit = 4'd0;
        case (seg)
            GLYPH_0: digit = 4'd0;
            GLYPH_1: digit = 4'd1;
            GLYPH_2: digit = 4'd2;
            GLYPH_3: digit = 4'd3;
            GLYPH_4: digit = 4'd4;
            GLYPH_5: digit = 4'd5;
            GLYPH_6: digit = 4'd6;
            GLYPH_7: digit = 4'd7;
            GLYPH_8: digit = 4'd8;
            GLYPH_9: digit = 4'd9;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the signed value shown on a multiplexed 4-digit 7-segment display by
// sampling SEG/AN, capturing each settled slot and converting a full frame.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              CLK,
    input  logic              RSTn,
    seg_scan_decoder_if.slave bus
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(TIMEOUT_CYC - 1);

    logic [6:0]          seg_s1_q, seg_s2_q, seg_prev_q;
    logic [3:0]          an_s1_q, an_s2_q, an_prev_q;
    logic [SETTLE_W-1:0] settle_d, settle_q;
    logic                armed_d, armed_q;
    logic [3:0]          mask_d, mask_q;
    logic [2:0][3:0]     slot_digit_d, slot_digit_q;
    logic                slot_minus_d, slot_minus_q;
    logic [3:0]          slot_bad_d, slot_bad_q;
    logic [2:0][3:0]     snap_digit_d, snap_digit_q;
    logic                snap_minus_d, snap_minus_q;
    logic [3:0]          snap_bad_d, snap_bad_q;
    logic [TMO_W-1:0]    tmo_cnt_d, tmo_cnt_q;
    logic                tmo_d, tmo_q;

    state_t      state_q;
    logic [9:0]  acc_q;
    logic [8:0]  value_q;
    logic [11:0] digits_q;
    logic        sign_q, valid_q, err_q;

    logic       changed, an_changed, one_low, capture, frame_full, tmo_fire;
    logic [1:0] slot_idx;
    logic       dec_bad;
    logic [3:0] dec_digit;
    logic [9:0] mag_final;
    logic       emit_err;

    seg_glyph_decode u_glyph (
        .seg   (seg_s2_q),
        .bad   (dec_bad),
        .digit (dec_digit)
    );

    assign changed    = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);
    assign an_changed = (an_s2_q != an_prev_q);

    always_comb begin
        one_low  = 1'b1;
        slot_idx = SLOT_UNITS;
        case (an_s2_q)
            4'b1110: slot_idx = SLOT_UNITS;
            4'b1101: slot_idx = SLOT_TENS;
            4'b1011: slot_idx = SLOT_HUNDREDS;
            4'b0111: slot_idx = SLOT_SIGN;
            default: one_low  = 1'b0;
        endcase
    end

    // armed blocks repeat captures during a long dwell until AN moves on
    always_comb begin
        settle_d = settle_q;
        armed_d  = armed_q;
        capture  = 1'b0;
        if (changed)
            settle_d = '0;
        else if (settle_q != SETTLE_MAX)
            settle_d = settle_q + 1'b1;
        if (an_changed)
            armed_d = 1'b1;
        if (!changed && settle_d == SETTLE_MAX && armed_q && one_low) begin
            capture = 1'b1;
            armed_d = 1'b0;
        end
    end

    assign frame_full = (state_q == ST_COLLECT) && (mask_q == 4'hF);
    assign tmo_fire   = (state_q == ST_COLLECT) && !capture && !frame_full &&
                        (mask_q != 4'h0) && (tmo_cnt_q == TMO_MAX);
    assign tmo_d      = tmo_fire;

    always_comb begin
        slot_digit_d = slot_digit_q;
        slot_minus_d = slot_minus_q;
        slot_bad_d   = slot_bad_q;
        snap_digit_d = snap_digit_q;
        snap_minus_d = snap_minus_q;
        snap_bad_d   = snap_bad_q;
        mask_d       = mask_q;
        tmo_cnt_d    = tmo_cnt_q;

        if (frame_full) begin
            snap_digit_d = slot_digit_q;
            snap_minus_d = slot_minus_q;
            snap_bad_d   = slot_bad_q;
        end
        if (frame_full || tmo_fire)
            mask_d = 4'h0;

        if (capture) begin
            mask_d[slot_idx] = 1'b1;
            case (slot_idx)
                SLOT_UNITS: begin
                    slot_digit_d[0] = dec_digit;
                    slot_bad_d[0]   = dec_bad;
                end
                SLOT_TENS: begin
                    slot_digit_d[1] = dec_digit;
                    slot_bad_d[1]   = dec_bad;
                end
                SLOT_HUNDREDS: begin
                    slot_digit_d[2] = dec_digit;
                    slot_bad_d[2]   = dec_bad;
                end
                default: begin
                    slot_minus_d  = (seg_s2_q == GLYPH_MINUS);
                    slot_bad_d[3] = !((seg_s2_q == GLYPH_MINUS) || (seg_s2_q == GLYPH_BLANK));
                end
            endcase
        end

        if (capture || mask_q == 4'h0 || tmo_fire)
            tmo_cnt_d = '0;
        else if (state_q == ST_COLLECT && tmo_cnt_q != TMO_MAX)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            seg_s1_q     <= '1;
            seg_s2_q     <= '1;
            seg_prev_q   <= '1;
            an_s1_q      <= '1;
            an_s2_q      <= '1;
            an_prev_q    <= '1;
            settle_q     <= '0;
            armed_q      <= 1'b1;
            mask_q       <= 4'h0;
            slot_digit_q <= '0;
            slot_minus_q <= 1'b0;
            slot_bad_q   <= 4'h0;
            snap_digit_q <= '0;
            snap_minus_q <= 1'b0;
            snap_bad_q   <= 4'h0;
            tmo_cnt_q    <= '0;
            tmo_q        <= 1'b0;
        end else begin
            seg_s1_q     <= bus.SEG;
            seg_s2_q     <= seg_s1_q;
            seg_prev_q   <= seg_s2_q;
            an_s1_q      <= bus.AN;
            an_s2_q      <= an_s1_q;
            an_prev_q    <= an_s2_q;
            settle_q     <= settle_d;
            armed_q      <= armed_d;
            mask_q       <= mask_d;
            slot_digit_q <= slot_digit_d;
            slot_minus_q <= slot_minus_d;
            slot_bad_q   <= slot_bad_d;
            snap_digit_q <= snap_digit_d;
            snap_minus_q <= snap_minus_d;
            snap_bad_q   <= snap_bad_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign mag_final = mul10_add(acc_q, snap_digit_q[0]);
    assign emit_err  = (|snap_bad_q) ||
                       (snap_minus_q ? (mag_final > 10'd256) : (mag_final > 10'd255));

    // Outputs are written in CONV_U so they are visible during the EMIT cycle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_COLLECT;
            acc_q    <= '0;
            value_q  <= '0;
            digits_q <= '0;
            sign_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (frame_full) begin
                        acc_q   <= '0;
                        state_q <= ST_CONV_H;
                    end
                end
                ST_CONV_H: begin
                    acc_q   <= mul10_add(acc_q, snap_digit_q[2]);
                    state_q <= ST_CONV_T;
                end
                ST_CONV_T: begin
                    acc_q   <= mul10_add(acc_q, snap_digit_q[1]);
                    state_q <= ST_CONV_U;
                end
                ST_CONV_U: begin
                    acc_q   <= mag_final;
                    valid_q <= 1'b1;
                    err_q   <= emit_err;
                    if (!emit_err) begin
                        value_q  <= snap_minus_q ? (~mag_final[8:0] + 9'd1) : mag_final[8:0];
                        digits_q <= snap_digit_q;
                        sign_q   <= snap_minus_q;
                    end
                    state_q <= ST_EMIT;
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign bus.VALUE  = value_q;
    assign bus.DIGITS = digits_q;
    assign bus.SIGN   = sign_q;
    assign bus.VALID  = valid_q;
    assign bus.ERR    = err_q;
    assign bus.TMO    = tmo_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: scanned frames push their expected
// result, a negedge monitor pops and compares on every VALID or TMO pulse.
module tb_seg_scan_decoder;

    localparam int SETTLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 2000;

    localparam logic [6:0] DIGIT_GLYPH [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [6:0] PLUS_GLYPH  = 7'b1111111;
    localparam logic [6:0] MINUS_GLYPH = 7'b1111110;

    typedef struct {
        bit          is_tmo;
        bit          err;
        logic [8:0]  value;
        logic [11:0] digits;
        bit          sign;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [8:0]  model_value  = '0;
    logic [11:0] model_digits = '0;
    bit          model_sign   = 1'b0;

    always #5 clk = ~clk;

    seg_scan_decoder_if bus_if ();

    seg_scan_decoder #(
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus_if)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic int glyph_to_digit(input logic [6:0] g);
        for (int i = 0; i < 10; i++)
            if (g == DIGIT_GLYPH[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0][6:0] make_glyphs(input int mag, input bit minus);
        logic [3:0][6:0] g;
        g[0] = DIGIT_GLYPH[mag % 10];
        g[1] = DIGIT_GLYPH[(mag / 10) % 10];
        g[2] = DIGIT_GLYPH[(mag / 100) % 10];
        g[3] = minus ? MINUS_GLYPH : PLUS_GLYPH;
        return g;
    endfunction

    function automatic logic [6:0] illegal_glyph(input int slot);
        logic [6:0] g;
        do begin
            g = 7'($urandom_range(0, 127));
        end while ((slot < 3) ? (glyph_to_digit(g) >= 0) : (g == PLUS_GLYPH || g == MINUS_GLYPH));
        return g;
    endfunction

    // Reference model: decimal value of the shown glyphs, with range/legality rules
    task automatic push_frame_expect(input logic [3:0][6:0] g);
        exp_t e;
        int   d [3];
        bit   bad;
        bit   minus;
        int   mag;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d[i] = glyph_to_digit(g[i]);
            if (d[i] < 0) begin
                bad  = 1'b1;
                d[i] = 0;
            end
        end
        minus = (g[3] == MINUS_GLYPH);
        if (!(minus || g[3] == PLUS_GLYPH)) bad = 1'b1;
        mag = d[2] * 100 + d[1] * 10 + d[0];
        e.is_tmo = 1'b0;
        e.err    = bad || (mag > (minus ? 256 : 255));
        if (!e.err) begin
            model_value  = minus ? 9'(-mag) : 9'(mag);
            model_digits = {4'(d[2]), 4'(d[1]), 4'(d[0])};
            model_sign   = minus;
        end
        e.value  = model_value;
        e.digits = model_digits;
        e.sign   = model_sign;
        exp_q.push_back(e);
    endtask

    task automatic push_tmo_expect();
        exp_t e;
        e.is_tmo = 1'b1;
        e.err    = 1'b0;
        e.value  = model_value;
        e.digits = model_digits;
        e.sign   = model_sign;
        exp_q.push_back(e);
    endtask

    task automatic drive_slot(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        bus_if.AN  = an;
        bus_if.SEG = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int slot, input logic [6:0] seg, input int cycles);
        drive_slot(~(4'b0001 << slot), seg, cycles);
        drive_slot(4'hF, PLUS_GLYPH, 3);
    endtask

    task automatic apply_stimulus(input logic [3:0][6:0] g, input int dwell, input bit shuffle);
        int order [4];
        int j, t;
        for (int i = 0; i < 4; i++) order[i] = i;
        if (shuffle) begin
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        push_frame_expect(g);
        for (int k = 0; k < 4; k++)
            drive_digit(order[k], g[order[k]], (dwell > 0) ? dwell : $urandom_range(20, 60));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_value"},  bus_if.VALUE,  9'h000);
        check_output({tag, "_digits"}, bus_if.DIGITS, 12'h000);
        check_output({tag, "_sign"},   bus_if.SIGN,   1'b0);
        check_output({tag, "_valid"},  bus_if.VALID,  1'b0);
        check_output({tag, "_err"},    bus_if.ERR,    1'b0);
        check_output({tag, "_tmo"},    bus_if.TMO,    1'b0);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus_if.VALID || bus_if.TMO)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_event actual VALID=%0b TMO=%0b expected no event",
                         bus_if.VALID, bus_if.TMO);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("event_tmo",   bus_if.TMO,   mon_e.is_tmo);
                check_output("event_valid", bus_if.VALID, !mon_e.is_tmo);
                check_output("err",         bus_if.ERR,   mon_e.err);
                check_output("value",       bus_if.VALUE, mon_e.value);
                check_output("digits",      bus_if.DIGITS, mon_e.digits);
                check_output("sign",        bus_if.SIGN,  mon_e.sign);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0][6:0] g;
        int              r;
        bit              minus;
        int              mag;

        bus_if.AN  = 4'hF;
        bus_if.SEG = PLUS_GLYPH;
        rst_n      = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        drive_slot(4'hF, PLUS_GLYPH, 10);

        $display("[TB] scan -37");
        apply_stimulus(make_glyphs(37, 1'b1), 50, 1'b0);
        $display("[TB] scan +255, -256, +300");
        apply_stimulus(make_glyphs(255, 1'b0), 50, 1'b0);
        apply_stimulus(make_glyphs(256, 1'b1), 50, 1'b0);
        apply_stimulus(make_glyphs(300, 1'b0), 50, 1'b0);
        g    = make_glyphs(12, 1'b0);
        g[0] = 7'b1111000;
        apply_stimulus(g, 50, 1'b1);

        $display("[TB] short units glitch inside a frame");
        g = make_glyphs(42, 1'b0);
        push_frame_expect(g);
        drive_digit(0, g[0], 40);
        drive_digit(0, DIGIT_GLYPH[8], SETTLE_CYC - 2);
        drive_digit(1, g[1], 40);
        drive_digit(2, g[2], 40);
        drive_digit(3, g[3], 40);

        $display("[TB] long dwell then partial frame timeout");
        g = make_glyphs(123, 1'b1);
        push_frame_expect(g);
        drive_digit(2, g[2], 40);
        drive_digit(1, g[1], 40);
        drive_digit(3, g[3], 40);
        drive_digit(0, g[0], 1000);
        push_tmo_expect();
        drive_digit(2, g[2], 40);
        drive_digit(1, g[1], 40);
        drive_digit(3, g[3], 40);
        drive_slot(4'hF, PLUS_GLYPH, TIMEOUT_CYC + 100);
        apply_stimulus(make_glyphs(5, 1'b0), 50, 1'b0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 20; n++) begin
            r     = $urandom_range(0, 9);
            minus = 1'($urandom_range(0, 1));
            if (r < 6) begin
                mag = minus ? $urandom_range(0, 256) : $urandom_range(0, 255);
                g   = make_glyphs(mag, minus);
            end else if (r < 8) begin
                g = make_glyphs($urandom_range(0, 999), minus);
            end else begin
                g    = make_glyphs($urandom_range(0, 255), minus);
                mag  = $urandom_range(0, 3);
                g[mag] = illegal_glyph(mag);
            end
            apply_stimulus(g, 0, 1'b1);
        end

        $display("[TB] reset during conversion");
        wait_drain(300);
        g = make_glyphs(99, 1'b1);
        drive_digit(0, g[0], 40);
        drive_digit(1, g[1], 40);
        drive_digit(2, g[2], 40);
        bus_if.AN  = 4'b0111;
        bus_if.SEG = g[3];
        repeat (20) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        bus_if.AN  = 4'hF;
        bus_if.SEG = PLUS_GLYPH;
        model_value  = '0;
        model_digits = '0;
        model_sign   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("midconv_reset");
        rst_n = 1'b1;
        drive_slot(4'hF, PLUS_GLYPH, 40);
        check_reset_outputs("after_reset");
        apply_stimulus(make_glyphs(128, 1'b1), 50, 1'b1);
        apply_stimulus(make_glyphs(0, 1'b1), 0, 1'b1);

        wait_drain(500);
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
